// File: rtl/hazard_scoreboard_unit.sv
// Hazard detection and forwarding for the pipeline, built on a shift-register
// scoreboard of in-flight instructions (EX, MEM_LAT memory stages, WB).
module hazard_scoreboard_unit #(
    parameter int REG_AW  = 5,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         id_valid,
    input  logic [REG_AW-1:0]            id_rs,
    input  logic [REG_AW-1:0]            id_rt,
    input  logic                         id_uses_rs,
    input  logic                         id_uses_rt,
    input  logic [REG_AW-1:0]            id_rd,
    input  logic                         id_reg_write,
    input  logic                         id_is_load,
    input  logic                         id_is_branch,
    input  logic                         flush,
    input  logic                         mem_busy,
    output logic                         pc_load,
    output logic                         IFID_Ld,
    output logic                         bubble,
    output logic                         ex_hold,
    output logic [$clog2(MEM_LAT+2)-1:0] fwd_ex_a,
    output logic [$clog2(MEM_LAT+2)-1:0] fwd_ex_b,
    output logic [$clog2(MEM_LAT+2)-1:0] fwd_id_a,
    output logic [$clog2(MEM_LAT+2)-1:0] fwd_id_b,
    output logic [CNT_W-1:0]             stall_cycles
);

    localparam int D  = MEM_LAT + 2;
    localparam int SW = $clog2(D);

    // Scoreboard: index 0 = EX, 1..MEM_LAT = memory stages, D-1 = WB.
    logic [D-1:0]             sb_valid;
    logic [D-1:0]             sb_reg_write;
    logic [D-1:0]             sb_is_load;
    logic [D-1:0][REG_AW-1:0] sb_rd;
    logic [REG_AW-1:0]        ex_rs;
    logic [REG_AW-1:0]        ex_rt;
    logic                     ex_uses_rs;
    logic                     ex_uses_rt;

    logic [D-1:0] live;
    logic [D-1:0] wr_id_a;
    logic [D-1:0] wr_id_b;
    logic [D-1:0] wr_ex_a;
    logic [D-1:0] wr_ex_b;
    logic [D-1:0] load_ready;
    logic [D-1:0] lu_window;
    logic [D-1:0] br_load_window;
    logic [D-1:0] stage0;
    logic [D-1:0] eligible;
    logic         load_stall;
    logic         branch_stall;
    logic         stall;
    logic         issue;

    // Youngest eligible producer in stages 1..D-1; 0 selects the register file.
    function automatic logic [SW-1:0] pick_stage(input logic [D-1:0] m);
        pick_stage = '0;
        for (int unsigned k = D - 1; k >= 1; k--) begin
            if (m[k]) pick_stage = SW'(k);
        end
    endfunction

    always_comb begin
        live           = '0;
        wr_id_a        = '0;
        wr_id_b        = '0;
        wr_ex_a        = '0;
        wr_ex_b        = '0;
        load_ready     = '0;
        lu_window      = '0;
        br_load_window = '0;
        stage0         = '0;
        for (int unsigned k = 0; k < D; k++) begin
            live[k]           = sb_valid[k] & sb_reg_write[k] & (sb_rd[k] != '0);
            wr_id_a[k]        = live[k] & id_uses_rs & (sb_rd[k] == id_rs);
            wr_id_b[k]        = live[k] & id_uses_rt & (sb_rd[k] == id_rt);
            wr_ex_a[k]        = live[k] & sb_valid[0] & ex_uses_rs & (sb_rd[k] == ex_rs);
            wr_ex_b[k]        = live[k] & sb_valid[0] & ex_uses_rt & (sb_rd[k] == ex_rt);
            load_ready[k]     = (k == D - 1);
            lu_window[k]      = (k <= D - 3);
            br_load_window[k] = (k <= D - 2);
            stage0[k]         = (k == 0);
        end
    end

    // A load only has data once it reaches WB.
    assign eligible = ~sb_is_load | load_ready;

    assign load_stall   = |((wr_id_a | wr_id_b) & sb_is_load & lu_window);
    assign branch_stall = id_is_branch &
                          (|((wr_id_a | wr_id_b) &
                             ((~sb_is_load & stage0) | (sb_is_load & br_load_window))));
    assign stall = id_valid & (load_stall | branch_stall);
    assign issue = id_valid & ~stall & ~flush;

    assign fwd_ex_a = pick_stage(wr_ex_a & eligible);
    assign fwd_ex_b = pick_stage(wr_ex_b & eligible);
    assign fwd_id_a = pick_stage(wr_id_a & eligible);
    assign fwd_id_b = pick_stage(wr_id_b & eligible);

    always_comb begin
        pc_load = 1'b1;
        IFID_Ld = 1'b1;
        bubble  = 1'b0;
        ex_hold = 1'b0;
        if (mem_busy) begin
            pc_load = 1'b0;
            IFID_Ld = 1'b0;
            ex_hold = 1'b1;
        end else if (stall) begin
            pc_load = 1'b0;
            IFID_Ld = 1'b0;
            bubble  = 1'b1;
        end else if (flush) begin
            bubble  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb_valid     <= '0;
            sb_reg_write <= '0;
            sb_is_load   <= '0;
            sb_rd        <= '0;
            ex_rs        <= '0;
            ex_rt        <= '0;
            ex_uses_rs   <= 1'b0;
            ex_uses_rt   <= 1'b0;
            stall_cycles <= '0;
        end else if (!mem_busy) begin
            sb_valid     <= {sb_valid[D-2:0], issue};
            sb_reg_write <= {sb_reg_write[D-2:0], issue & id_reg_write};
            sb_is_load   <= {sb_is_load[D-2:0], issue & id_is_load};
            sb_rd        <= {sb_rd[D-2:0], (issue ? id_rd : {REG_AW{1'b0}})};
            ex_rs        <= issue ? id_rs : '0;
            ex_rt        <= issue ? id_rt : '0;
            ex_uses_rs   <= issue & id_uses_rs;
            ex_uses_rt   <= issue & id_uses_rt;
            if (stall && (stall_cycles != '1))
                stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule
